nv_nvdla_pdp_core_unit1d_pool_acc: RTL and testbench
====================================================

Name: nv_nvdla_pdp_core_unit1d_pool_acc

Overview:
- Downstream consumer of the unit1d d2 pipe stage. Takes its valid/ready stream of per-lane pooling elements and folds consecutive beats into one 1D pooling window (sum, max or min).
- Emits one result beat per window to the next pipe stage.
- Holds one registered result; backpressure propagates upstream through in_rdy.

Parameters:
- LANES, 8, number of parallel data lanes per beat
- DATA_W, 16, signed element width per lane
- ACC_W, DATA_W+3, signed accumulator/result width per lane; covers a sum of 8 elements

Ports:
- nvdla_core_clk  in  1  clock
- nvdla_core_rstn  in  1  reset
- reg2dp_pool_method  in  2  0=sum, 1=max, 2=min, 3=reserved (treated as sum)
- reg2dp_kernel_width  in  3  window length minus 1 (1..8 elements)
- in_vld  in  1  input beat valid
- in_rdy  out  1  input beat accepted when in_vld&&in_rdy
- in_pd  in  LANES*DATA_W  lane data; lane i at bits [i*DATA_W +: DATA_W]
- in_line_end  in  1  beat is last of line; closes the window early
- out_vld  out  1  result valid
- out_rdy  in  1  downstream ready
- out_pd  out  LANES*ACC_W  per-lane result, lane i at [i*ACC_W +: ACC_W]
- out_cnt  out  4  number of elements folded into out_pd (1..8)

Reset and clocking: reset is nvdla_core_rstn, asynchronous, active-low; clock is nvdla_core_clk.

Behaviour:
- Reset values:
  - out_vld=0, out_pd=0, out_cnt=0
  - internal element count cnt=0, accumulator=0
  - latched method=0, latched kernel=0
- Handshake:
  - in_rdy = !out_vld || out_rdy. This is a combinational path from out_rdy, the same style as the upstream pipe.
  - out_vld/out_pd/out_cnt hold stable while out_vld && !out_rdy.
- Config latching: method and kernel_width are sampled on an accepted beat when cnt==0, i.e. at window start. Changes mid-window have no effect until the next window.
- Accepted beat with cnt==0:
  - acc = sign_extend(in_pd lane) per lane; cnt=1.
- Accepted beat with cnt>0, per lane:
  - sum: acc = acc + sext(data)
  - max: acc = (sext(data) > acc) ? sext(data) : acc (signed)
  - min: same compare with <
  - cnt = cnt+1
- Window close: the accepted beat closes the window when (cnt_next == kernel_latched+1) or in_line_end.
  - The next cycle out_pd = folded result including this beat, out_cnt = cnt_next, out_vld=1.
  - cnt returns to 0.
  - Latency: 1 cycle from the closing beat to out_vld.
- Output drain: out_vld clears on out_vld&&out_rdy unless a new window closes in the same cycle. In that case out_vld stays 1 and the output registers load the new result (back-to-back, full throughput with kernel_width=0).
- kernel_width=0: every beat is a window; out_pd = sign-extended input.
- in_line_end on the first beat of a window gives out_cnt=1.
- Sum arithmetic: never overflows, since ACC_W holds 8*(-2^(DATA_W-1)). No saturation or rounding; averaging is done downstream using out_cnt.
- Reset mid-window: the partial accumulation is discarded and any pending result is dropped.

Optional Feature:
- Macro NV_NVDLA_PDP_UNIT1D_POOL_PERF_EN.
- Defined:
  - Adds output port dp2reg_pool_win_cnt (32 bits).
  - Increments on each out_vld&&out_rdy; saturates at 0xFFFFFFFF; reset to 0.
  - Also adds output dp2reg_pool_stall_cnt (32 bits): counts cycles with out_vld&&!out_rdy, same saturation and reset.
- Undefined: neither port nor its counter logic exists; all other behaviour is identical.

Decomposition:
- Shared package nv_nvdla_pdp_unit1d_pkg holds:
  - pool-method encodings POOL_SUM/POOL_MAX/POOL_MIN
  - default LANES/DATA_W
  - ACC_W derivation
  - max-kernel constant (8)
- One sub-module is natural: nv_nvdla_pdp_unit1d_pool_lane, the per-lane fold unit (first/sum/max/min select), instantiated LANES times with a generate loop.
- The top level holds the counter, config latch, output register and handshake.

Test Plan:
- Sum, kernel_width=2 (3 elements), lane0 inputs 5,-3,10, no stall -> one out beat, lane0 = 12, out_cnt=3, out_vld 1 cycle after the third accept.
- Max, kernel_width=3, lane1 inputs -7,-2,-9,-4 -> lane1 = -2; same window with method min -> lane1 = -9 (sign-extended to ACC_W).
- Sum, kernel_width=7, every lane -32768 for 8 beats -> every lane = -262144, no overflow.
- Sum, kernel_width=7, in_line_end asserted on the 3rd beat -> out_cnt=3; the next window restarts at cnt=0 with freshly sampled config.
- kernel_width=0 streaming with out_rdy held low for 4 cycles:
  - out_pd is held stable while stalled, and in_rdy=0 during the stall.
  - Once out_rdy is released, one result is delivered per cycle with no loss or duplication (scoreboard).
- Reset asserted mid-window (cnt=2) -> out_vld=0, and the next window result contains only post-reset beats.
- With NV_NVDLA_PDP_UNIT1D_POOL_PERF_EN defined: the win/stall counters match the scoreboard counts.

Source files
------------

// File: rtl/nv_nvdla_pdp_unit1d_pkg.sv
// Shared types and constants for the PDP unit1d pooling accumulator.
// Perf counters are built in when NV_NVDLA_PDP_UNIT1D_POOL_PERF_EN is defined.
package nv_nvdla_pdp_unit1d_pkg;

  typedef enum logic [1:0] {
    POOL_SUM  = 2'd0,
    POOL_MAX  = 2'd1,
    POOL_MIN  = 2'd2,
    POOL_RSVD = 2'd3
  } pool_method_e;

  localparam int LANES_DEF  = 8;
  localparam int DATA_W_DEF = 16;
  localparam int MAX_KERNEL = 8;

  function automatic int acc_w(int dw);
    return dw + $clog2(MAX_KERNEL);
  endfunction

endpackage

// File: rtl/nv_nvdla_pdp_unit1d_pool_lane.sv
// Per-lane fold unit: first element, running sum, max or min.
// Reserved method encodings fold as a sum.
module nv_nvdla_pdp_unit1d_pool_lane
  import nv_nvdla_pdp_unit1d_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = acc_w(DATA_W_DEF)
) (
  input  logic              first,
  input  logic [1:0]        method,
  input  logic [DATA_W-1:0] data,
  input  logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  nxt
);

  logic signed [ACC_W-1:0] d_ext;
  logic signed [ACC_W-1:0] a_s;

  assign d_ext = {{(ACC_W-DATA_W){data[DATA_W-1]}}, data};
  assign a_s   = acc;

  always_comb begin
    nxt = d_ext;
    if (!first) begin
      case (pool_method_e'(method))
        POOL_MAX: nxt = (d_ext > a_s) ? d_ext : a_s;
        POOL_MIN: nxt = (d_ext < a_s) ? d_ext : a_s;
        default:  nxt = a_s + d_ext;
      endcase
    end
  end

endmodule

// File: rtl/nv_nvdla_pdp_core_unit1d_pool_acc.sv
// Folds unit1d beats into 1D pooling windows; one result beat per window.
// NV_NVDLA_PDP_UNIT1D_POOL_PERF_EN adds window/stall counters.
module nv_nvdla_pdp_core_unit1d_pool_acc
  import nv_nvdla_pdp_unit1d_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = acc_w(DATA_W)
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic [1:0]              reg2dp_pool_method,
  input  logic [2:0]              reg2dp_kernel_width,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [LANES*DATA_W-1:0] in_pd,
  input  logic                    in_line_end,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [LANES*ACC_W-1:0]  out_pd,
  output logic [3:0]              out_cnt
`ifdef NV_NVDLA_PDP_UNIT1D_POOL_PERF_EN
  ,
  output logic [31:0]             dp2reg_pool_win_cnt,
  output logic [31:0]             dp2reg_pool_stall_cnt
`endif
);

  logic [3:0]             cnt_q;
  logic [LANES*ACC_W-1:0] acc_q;
  logic [1:0]             method_q;
  logic [2:0]             kernel_q;

  logic                   fire;
  logic                   first;
  logic [1:0]             method_eff;
  logic [2:0]             kernel_eff;
  logic [3:0]             cnt_nxt;
  logic [3:0]             kern_lim;
  logic                   close;
  logic [LANES*ACC_W-1:0] acc_nxt;

  assign in_rdy     = !out_vld || out_rdy;
  assign fire       = in_vld && in_rdy;
  assign first      = (cnt_q == 4'd0);
  // Config is live on the opening beat, latched copy afterwards
  assign method_eff = first ? reg2dp_pool_method : method_q;
  assign kernel_eff = first ? reg2dp_kernel_width : kernel_q;
  assign cnt_nxt    = cnt_q + 4'd1;
  assign kern_lim   = {1'b0, kernel_eff} + 4'd1;
  assign close      = fire && ((cnt_nxt == kern_lim) || in_line_end);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    nv_nvdla_pdp_unit1d_pool_lane #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_lane (
      .first  (first),
      .method (method_eff),
      .data   (in_pd[i*DATA_W +: DATA_W]),
      .acc    (acc_q[i*ACC_W +: ACC_W]),
      .nxt    (acc_nxt[i*ACC_W +: ACC_W])
    );
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      method_q <= '0;
      kernel_q <= '0;
    end else if (fire) begin
      acc_q <= acc_nxt;
      cnt_q <= close ? 4'd0 : cnt_nxt;
      if (first) begin
        method_q <= reg2dp_pool_method;
        kernel_q <= reg2dp_kernel_width;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_vld <= 1'b0;
      out_pd  <= '0;
      out_cnt <= '0;
    end else if (close) begin
      out_vld <= 1'b1;
      out_pd  <= acc_nxt;
      out_cnt <= cnt_nxt;
    end else if (out_vld && out_rdy) begin
      out_vld <= 1'b0;
    end
  end

`ifdef NV_NVDLA_PDP_UNIT1D_POOL_PERF_EN
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      dp2reg_pool_win_cnt   <= '0;
      dp2reg_pool_stall_cnt <= '0;
    end else begin
      if (out_vld && out_rdy && (dp2reg_pool_win_cnt != '1))
        dp2reg_pool_win_cnt <= dp2reg_pool_win_cnt + 32'd1;
      if (out_vld && !out_rdy && (dp2reg_pool_stall_cnt != '1))
        dp2reg_pool_stall_cnt <= dp2reg_pool_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nv_nvdla_pdp_core_unit1d_pool_acc.sv
// Scoreboard bench for the unit1d pooling accumulator.
// Expected windows are queued by stimulus and popped by a monitor.
module tb_nv_nvdla_pdp_core_unit1d_pool_acc;

  localparam int LANES  = 8;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 19;
  localparam int PW     = LANES*ACC_W;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [1:0]              method;
  logic [2:0]              kernel;
  logic                    in_vld;
  logic                    in_rdy;
  logic [LANES*DATA_W-1:0] in_pd;
  logic                    in_line_end;
  logic                    out_vld;
  logic                    out_rdy;
  logic [PW-1:0]           out_pd;
  logic [3:0]              out_cnt;
`ifdef NV_NVDLA_PDP_UNIT1D_POOL_PERF_EN
  logic [31:0]             win_cnt;
  logic [31:0]             stall_cnt;
`endif

  always #5 clk = ~clk;

  nv_nvdla_pdp_core_unit1d_pool_acc dut (
    .nvdla_core_clk      (clk),
    .nvdla_core_rstn     (rst_n),
    .reg2dp_pool_method  (method),
    .reg2dp_kernel_width (kernel),
    .in_vld              (in_vld),
    .in_rdy              (in_rdy),
    .in_pd               (in_pd),
    .in_line_end         (in_line_end),
    .out_vld             (out_vld),
    .out_rdy             (out_rdy),
    .out_pd              (out_pd),
    .out_cnt             (out_cnt)
`ifdef NV_NVDLA_PDP_UNIT1D_POOL_PERF_EN
    ,
    .dp2reg_pool_win_cnt   (win_cnt),
    .dp2reg_pool_stall_cnt (stall_cnt)
`endif
  );

  typedef int vec_t [LANES];
  typedef struct {
    logic [PW-1:0] pd;
    logic [3:0]    cnt;
    string         name;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   n_win   = 0;
  int   n_stall = 0;

  function automatic logic [LANES*DATA_W-1:0] pack_in(vec_t v);
    logic [LANES*DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v[i]);
    return r;
  endfunction

  function automatic logic [PW-1:0] pack_acc(vec_t v);
    logic [PW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*ACC_W +: ACC_W] = ACC_W'(v[i]);
    return r;
  endfunction

  function automatic vec_t fill(int x);
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = x;
    return v;
  endfunction

  task automatic chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic expect_win(string nm, vec_t v, int c);
    exp_t e;
    e.pd   = pack_acc(v);
    e.cnt  = 4'(c);
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic send(vec_t v, logic le);
    int n = 0;
    in_pd       = pack_in(v);
    in_line_end = le;
    in_vld      = 1'b1;
    #1;
    while (!in_rdy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (!in_rdy) begin
      errors++;
      $display("FAIL send_timeout in_rdy got 0 want 1");
    end
    @(posedge clk);
    @(negedge clk);
    in_vld      = 1'b0;
    in_line_end = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || out_vld) && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_vld) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst_n) begin
      n_win   = 0;
      n_stall = 0;
    end else begin
      if (out_vld && !out_rdy) n_stall++;
      if (out_vld && out_rdy) begin
        n_win++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %h want none", out_pd);
        end else begin
          e = sb.pop_front();
          if (out_pd !== e.pd || out_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s got %h/%0d want %h/%0d",
                     e.name, out_pd, out_cnt, e.pd, e.cnt);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    rst_n       = 1'b0;
    in_vld      = 1'b0;
    in_pd       = '0;
    in_line_end = 1'b0;
    out_rdy     = 1'b1;
    method      = 2'd0;
    kernel      = 3'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_vld", PW'(out_vld), PW'(0));
    chk("rst_out_pd",  out_pd,       '0);
    chk("rst_out_cnt", PW'(out_cnt), PW'(0));
    chk("rst_in_rdy",  PW'(in_rdy),  PW'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // sum of three, latency check
    method = 2'd0; kernel = 3'd2;
    v = fill(0); v[0] = 5;  send(v, 1'b0);
    v[0] = -3;              send(v, 1'b0);
    #1;
    chk("t1_not_early", PW'(out_vld), PW'(0));
    v = fill(0); v[0] = 12; expect_win("t1_sum", v, 3);
    v[0] = 10;              send(v, 1'b0);
    #1;
    chk("t1_latency", PW'(out_vld), PW'(1));
    drain();

    // max then min over the same four beats
    for (int m = 1; m <= 2; m++) begin
      method = 2'(m); kernel = 3'd3;
      v = fill(0); v[1] = -7; send(v, 1'b0);
      v[1] = -2;              send(v, 1'b0);
      v[1] = -9;              send(v, 1'b0);
      v = fill(0); v[1] = (m == 1) ? -2 : -9;
      expect_win(m == 1 ? "t2_max" : "t2_min", v, 4);
      v[1] = -4;              send(v, 1'b0);
      drain();
    end

    // full-scale negative sum over eight beats
    method = 2'd0; kernel = 3'd7;
    expect_win("t3_sum_min", fill(-262144), 8);
    for (int j = 0; j < 8; j++) send(fill(-32768), 1'b0);
    drain();

    // line end closes early; mid-window config change ignored
    method = 2'd0; kernel = 3'd7;
    send(fill(100), 1'b0);
    method = 2'd1; kernel = 3'd1;
    send(fill(200), 1'b0);
    expect_win("t4_line_end", fill(600), 3);
    send(fill(300), 1'b1);
    send(fill(4), 1'b0);
    expect_win("t4_fresh_cfg", fill(9), 2);
    send(fill(9), 1'b0);
    drain();

    // reserved method folds as sum; line end on first beat
    method = 2'd3; kernel = 3'd1;
    send(fill(7), 1'b0);
    expect_win("t5_rsvd_sum", fill(-1), 2);
    send(fill(-8), 1'b0);
    method = 2'd0; kernel = 3'd7;
    expect_win("t5_first_le", fill(-5), 1);
    send(fill(-5), 1'b1);
    drain();

    // kernel 0 streaming with a four-cycle stall
    method  = 2'd0; kernel = 3'd0;
    out_rdy = 1'b0;
    fork
      begin
        vec_t s;
        for (int j = 0; j < 6; j++) begin
          s = fill(-j);
          s[0] = 11*(j+1);
          expect_win("t6_stream", s, 1);
          send(s, 1'b0);
        end
      end
      begin
        vec_t h;
        int n = 0;
        h = fill(0); h[0] = 11;
        while (!out_vld && n < 50) begin
          @(negedge clk);
          #2;
          n++;
        end
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          #2;
          chk("t6_stall_vld",  PW'(out_vld), PW'(1));
          chk("t6_stall_hold", out_pd,       pack_acc(h));
          chk("t6_stall_rdy",  PW'(in_rdy),  PW'(0));
        end
        @(negedge clk);
        out_rdy = 1'b1;
      end
    join
    drain();

    // reset in the middle of a window
    method = 2'd0; kernel = 3'd3;
    send(fill(1000), 1'b0);
    send(fill(2000), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_vld", PW'(out_vld), PW'(0));
    chk("t7_rst_cnt", PW'(out_cnt), PW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(fill(1), 1'b0);
    send(fill(2), 1'b0);
    send(fill(3), 1'b0);
    expect_win("t7_post_rst", fill(10), 4);
    send(fill(4), 1'b0);
    drain();

`ifdef NV_NVDLA_PDP_UNIT1D_POOL_PERF_EN
    chk("perf_win",   PW'(win_cnt),   PW'(n_win));
    chk("perf_stall", PW'(stall_cnt), PW'(n_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
